herloa_share_arb: RTL and testbench

//  Shares one hybrid approximate adder datapath (OR-based lower part, exact upper part) among NREQ requesters.

---
 rtl/herloa_pkg.sv | 41 ++++
 rtl/herloa_share_arb_if.sv | 38 +++
 rtl/herloa_dp.sv | 41 ++++
 rtl/herloa_share_arb.sv | 183 ++++++++++++++++++
 tb/tb_herloa_share_arb.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/herloa_pkg.sv
// -----------------------------------------------------------------------------
// herloa_pkg
// Shared constants and helpers for the hybrid approximate adder (HERLOA).
//   HERLOA_N / HERLOA_P / HERLOA_M / HERLOA_NREQ : default configuration
//   herloa_params_ok(n, p, m) : legality check (4 <= P <= N-1, 1 <= M <= P-2)
//   herloa_ref(x, y)          : approximate sum for the default N/P/M
// -----------------------------------------------------------------------------
package herloa_pkg;

    localparam int unsigned HERLOA_N    = 16;
    localparam int unsigned HERLOA_P    = 8;
    localparam int unsigned HERLOA_M    = 4;
    localparam int unsigned HERLOA_NREQ = 4;

    function automatic bit herloa_params_ok(input int unsigned n,
                                            input int unsigned p,
                                            input int unsigned m);
        return (p >= 4) && (p <= n - 1) && (m >= 1) && (m + 2 <= p);
    endfunction

    function automatic logic [HERLOA_N:0] herloa_ref(input logic [HERLOA_N-1:0] x,
                                                     input logic [HERLOA_N-1:0] y);
        logic                       a0;
        logic                       a1;
        logic [HERLOA_P-1:0]        lo;
        logic [HERLOA_N-HERLOA_P:0] hi;
        a0 = x[HERLOA_P-1] ^ y[HERLOA_P-1];
        a1 = x[HERLOA_P-2] & y[HERLOA_P-2];
        lo = '0;
        lo[HERLOA_P-1] = a0 | a1;
        lo[HERLOA_P-2] = (a0 | ~a1) & (x[HERLOA_P-2] | y[HERLOA_P-2]);
        for (int unsigned i = HERLOA_M; i <= HERLOA_P - 3; i++) begin
            lo[i] = x[i] | y[i] | (a0 & a1);
        end
        lo[HERLOA_M-1:0] = '1;
        hi = {1'b0, x[HERLOA_N-1:HERLOA_P]} + {1'b0, y[HERLOA_N-1:HERLOA_P]}
           + {{(HERLOA_N-HERLOA_P){1'b0}}, x[HERLOA_P-1] & y[HERLOA_P-1]};
        return {hi, lo};
    endfunction

endpackage

// File: rtl/herloa_share_arb_if.sv
// -----------------------------------------------------------------------------
// herloa_share_arb_if
// Handshake bundle between the requesters / result consumer and the shared
// approximate adder.
//   req_valid/req_ready : per-requester valid/ready (NREQ bits)
//   req_x/req_y         : packed operands, requester i at [i*N +: N]
//   out_valid/out_ready : result handshake
//   out_sum             : approximate sum {cout, s} (N+1 bits)
//   out_id              : index of the requester owning out_sum
//   busy                : any pipeline stage holds data
// Modports: master = producer/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface herloa_share_arb_if #(
    parameter int unsigned N    = 16,
    parameter int unsigned NREQ = 4
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_x;
    logic [NREQ*N-1:0] req_y;
    logic              out_valid;
    logic              out_ready;
    logic [N:0]        out_sum;
    logic [IDW-1:0]    out_id;
    logic              busy;

    modport master (
        output req_valid, req_x, req_y, out_ready,
        input  req_ready, out_valid, out_sum, out_id, busy
    );

    modport slave (
        input  req_valid, req_x, req_y, out_ready,
        output req_ready, out_valid, out_sum, out_id, busy
    );
endinterface

// File: rtl/herloa_dp.sv
// -----------------------------------------------------------------------------
// herloa_dp
// Purely combinational hybrid approximate adder.
//   x_i, y_i : N-bit operands
//   sum_o    : N+1-bit approximate sum {cout, s}
// Bits [N-1:P] are added exactly with a carry-in of X[P-1]&Y[P-1]; bits
// [P-1:M] use OR-based approximation; bits [M-1:0] are forced to one.
// -----------------------------------------------------------------------------
module herloa_dp
    import herloa_pkg::*;
#(
    parameter int unsigned N = HERLOA_N,
    parameter int unsigned P = HERLOA_P,
    parameter int unsigned M = HERLOA_M
) (
    input  logic [N-1:0] x_i,
    input  logic [N-1:0] y_i,
    output logic [N:0]   sum_o
);

    logic         a0;
    logic         a1;
    logic [P-1:0] lo;
    logic [N-P:0] hi;

    always_comb begin
        a0 = x_i[P-1] ^ y_i[P-1];
        a1 = x_i[P-2] & y_i[P-2];
        lo = '0;
        lo[P-1] = a0 | a1;
        lo[P-2] = (a0 | ~a1) & (x_i[P-2] | y_i[P-2]);
        for (int unsigned i = M; i <= P - 3; i++) begin
            lo[i] = x_i[i] | y_i[i] | (a0 & a1);
        end
        lo[M-1:0] = '1;
        hi = {1'b0, x_i[N-1:P]} + {1'b0, y_i[N-1:P]}
           + {{(N-P){1'b0}}, x_i[P-1] & y_i[P-1]};
        sum_o = {hi, lo};
    end

endmodule

// File: rtl/herloa_share_arb.sv
// -----------------------------------------------------------------------------
// herloa_share_arb
// Round-robin arbiter sharing one herloa_dp among NREQ requesters through a
// 2-stage pipeline (S1 = operands + id, S2 = sum + id + valid).
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bus       : herloa_share_arb_if.slave (requests, result, busy)
//   stats_clr : clear error statistics
//   err_cnt   : number of results with approx != exact (saturating)
//   err_acc   : sum of |approx - exact| (saturating)
// Optional feature macro: HERLOA_ERR_STATS_EN enables the exact adder and the
// error statistics; when undefined err_cnt/err_acc are 0 and stats_clr is
// ignored.
// -----------------------------------------------------------------------------
module herloa_share_arb
    import herloa_pkg::*;
#(
    parameter int unsigned N    = HERLOA_N,
    parameter int unsigned P    = HERLOA_P,
    parameter int unsigned M    = HERLOA_M,
    parameter int unsigned NREQ = HERLOA_NREQ
) (
    input  logic                     clk,
    input  logic                     rst,
    herloa_share_arb_if.slave        bus,
    input  logic                     stats_clr,
    output logic [31:0]              err_cnt,
    output logic [39:0]              err_acc
);

    localparam int unsigned IDW = $clog2(NREQ);

    logic           s1_valid_q, s1_valid_d;
    logic [N-1:0]   s1_x_q, s1_x_d;
    logic [N-1:0]   s1_y_q, s1_y_d;
    logic [IDW-1:0] s1_id_q, s1_id_d;
    logic           s2_valid_q, s2_valid_d;
    logic [N:0]     s2_sum_q, s2_sum_d;
    logic [IDW-1:0] s2_id_q, s2_id_d;
    logic [IDW-1:0] ptr_q, ptr_d;

    logic           s2_load;
    logic           s1_free;
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    int unsigned    scan_idx;
    logic           accept;
    logic [N:0]     dp_sum;

    herloa_dp #(.N(N), .P(P), .M(M)) u_dp (
        .x_i   (s1_x_q),
        .y_i   (s1_y_q),
        .sum_o (dp_sum)
    );

    assign s2_load = s1_valid_q & (~s2_valid_q | bus.out_ready);
    assign s1_free = ~s1_valid_q | s2_load;

    // Scan starts just after the last granted requester, so reset ptr=NREQ-1
    // gives requester 0 top priority.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            scan_idx = (32'(ptr_q) + k) % NREQ;
            if (!gnt_found && bus.req_valid[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(scan_idx);
            end
        end
    end

    // Ready is masked during reset so no handshake can slip through.
    assign accept = gnt_found & s1_free & ~rst;

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        s1_x_d  = s1_x_q;
        s1_y_d  = s1_y_q;
        s1_id_d = s1_id_q;
        ptr_d   = ptr_q;
        s2_sum_d = s2_sum_q;
        s2_id_d  = s2_id_q;
        if (accept) begin
            s1_x_d  = bus.req_x[gnt_idx*N +: N];
            s1_y_d  = bus.req_y[gnt_idx*N +: N];
            s1_id_d = gnt_idx;
            ptr_d   = gnt_idx;
        end
        s1_valid_d = accept | (s1_valid_q & ~s2_load);
        if (s2_load) begin
            s2_sum_d = dp_sum;
            s2_id_d  = s1_id_q;
        end
        s2_valid_d = s2_load | (s2_valid_q & ~bus.out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            s2_sum_q   <= '0;
            s2_id_q    <= '0;
            ptr_q      <= IDW'(NREQ - 1);
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            s2_sum_q   <= s2_sum_d;
            s2_id_q    <= s2_id_d;
            ptr_q      <= ptr_d;
        end
    end

    assign bus.out_valid = s2_valid_q;
    assign bus.out_sum   = s2_sum_q;
    assign bus.out_id    = s2_id_q;
    assign bus.busy      = s1_valid_q | s2_valid_q;

`ifdef HERLOA_ERR_STATS_EN
    logic [N:0]  exact;
    logic [N:0]  diff;
    logic [40:0] acc_sum;
    logic [31:0] err_cnt_q, err_cnt_d;
    logic [39:0] err_acc_q, err_acc_d;

    always_comb begin
        exact   = {1'b0, s1_x_q} + {1'b0, s1_y_q};
        diff    = (dp_sum >= exact) ? (dp_sum - exact) : (exact - dp_sum);
        acc_sum = {1'b0, err_acc_q} + {{(40-N){1'b0}}, diff};
        err_cnt_d = err_cnt_q;
        err_acc_d = err_acc_q;
        if (stats_clr) begin
            err_cnt_d = '0;
            err_acc_d = '0;
        end else if (s2_load) begin
            if ((dp_sum != exact) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end
            err_acc_d = acc_sum[40] ? '1 : acc_sum[39:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
            err_acc_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_acc_q <= err_acc_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_acc = err_acc_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr;
    assign err_cnt = '0;
    assign err_acc = '0;
`endif

    // Producers must hold valid and operands until accepted.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_hold
        a_hold: assert property (@(posedge clk) disable iff (rst)
            (bus.req_valid[gi] && !bus.req_ready[gi]) |=>
            (bus.req_valid[gi] && $stable(bus.req_x[gi*N +: N])
                               && $stable(bus.req_y[gi*N +: N])));
    end

endmodule

// File: tb/tb_herloa_share_arb.sv
module tb_herloa_share_arb;

    localparam int N    = 16;
    localparam int NREQ = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stats_clr = 1'b0;
    logic [31:0] err_cnt;
    logic [39:0] err_acc;

    always #5 clk = ~clk;

    herloa_share_arb_if #(.N(N), .NREQ(NREQ)) bus ();

    herloa_share_arb #(.N(16), .P(8), .M(4), .NREQ(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .stats_clr (stats_clr),
        .err_cnt   (err_cnt),
        .err_acc   (err_acc)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
        end
    endtask

    // Expected statistics collapse to zero when the feature is compiled out.
    function automatic longint unsigned st(input longint unsigned v);
`ifdef HERLOA_ERR_STATS_EN
        return v;
`else
        return v - v;
`endif
    endfunction

    // Behavioural reference: exact upper part with carry-in, OR-style lower bits.
    function automatic logic [16:0] ref_approx(input logic [15:0] x, input logic [15:0] y);
        int unsigned hi, lo;
        bit a0, a1;
        hi = int'(x >> 8) + int'(y >> 8) + int'(x[7] & y[7]);
        a0 = x[7] ^ y[7];
        a1 = x[6] & y[6];
        lo = 15;
        if (a0 | a1) lo += 128;
        if ((a0 | !a1) && (x[6] | y[6])) lo += 64;
        for (int b = 4; b < 6; b++) if (x[b] | y[b] | (a0 & a1)) lo += (1 << b);
        return 17'(hi * 256 + lo);
    endfunction

    // ---------------- system-level model ----------------
    typedef struct { logic [16:0] sum; int id; int age; } item_t;
    item_t             mq[$];
    int                m_ptr;
    longint unsigned   m_cnt, m_acc;
    logic [NREQ-1:0]   pv;
    logic [15:0]       px[NREQ];
    logic [15:0]       py[NREQ];
    int                cyc = 0;
    bit                rec = 0;
    int                seen_id[$];
    int                seen_cyc[$];

    task automatic model_reset();
        mq.delete();
        m_ptr = NREQ - 1;
        m_cnt = 0;
        m_acc = 0;
    endtask

    // One clock: drive, check against the model, then advance the model
    // across the coming edge. Pipeline = at most 2 items; head is visible
    // once it has been through one edge.
    task automatic model_cycle(input bit ordy, input int prob);
        int g;
        bit any, free, vis, hs;
        logic [NREQ-1:0] exp_rdy;
        item_t it;
        int unsigned ex, ap;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc++;
        bus.out_ready = ordy;
        bus.req_valid = pv;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_x[i*N +: N] = px[i];
            bus.req_y[i*N +: N] = py[i];
        end
        #1;
        vis  = (mq.size() > 0) && (mq[0].age >= 1);
        free = (mq.size() < 2) || ordy;
        any = 0; g = 0;
        for (int k = 1; k <= NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (!any && pv[c]) begin any = 1; g = c; end
        end
        hs = any && free;
        exp_rdy = '0;
        if (hs) exp_rdy[g] = 1'b1;
        chk("req_ready", bus.req_ready, exp_rdy);
        chk("out_valid", bus.out_valid, vis);
        chk("busy", bus.busy, mq.size() > 0);
        if (vis) begin
            chk("out_sum", bus.out_sum, mq[0].sum);
            chk("out_id", bus.out_id, mq[0].id);
        end
        if (rec && bus.out_valid === 1'b1 && ordy) begin
            seen_id.push_back(int'(bus.out_id));
            seen_cyc.push_back(cyc);
        end
        if (vis && ordy) void'(mq.pop_front());
        foreach (mq[j]) mq[j].age++;
        if (hs) begin
            it.sum = ref_approx(px[g], py[g]);
            it.id  = g;
            it.age = 0;
            mq.push_back(it);
            m_ptr = g;
            ex = int'(px[g]) + int'(py[g]);
            ap = int'(it.sum);
            if (ap != ex) m_cnt++;
            m_acc += (ap > ex) ? (ap - ex) : (ex - ap);
            pv[g] = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!pv[i] && $urandom_range(99) < prob) begin
                pv[i] = 1'b1;
                px[i] = 16'($urandom);
                py[i] = 16'($urandom);
            end
        end
    endtask

    task automatic drain();
        for (int w = 0; w < 60 && (mq.size() > 0 || pv != '0); w++) model_cycle(1'b1, 0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_err_cnt"}, err_cnt, st(m_cnt));
        chk({tag, "_err_acc"}, err_acc, st(m_acc));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_err_acc", err_acc, 0);
        chk("rst_req_ready", bus.req_ready, 0);
        model_reset();
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          req;
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] sum;
        int          dcnt;
        int          dacc;
    } vec_t;

    vec_t            vecs[6];
    longint unsigned t_cnt = 0, t_acc = 0;

    task automatic run_vec(input vec_t v);
        int w;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.req_valid = '0;
        bus.req_valid[v.req] = 1'b1;
        bus.req_x[v.req*N +: N] = v.x;
        bus.req_y[v.req*N +: N] = v.y;
        #1;
        w = 0;
        while (bus.req_ready[v.req] !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        chk("vec_accept", bus.req_ready[v.req], 1);
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("vec_lat1_valid", bus.out_valid, 0);
        chk("vec_lat1_busy", bus.busy, 1);
        @(posedge clk); #1;
        t_cnt += v.dcnt;
        t_acc += v.dacc;
        chk("vec_out_valid", bus.out_valid, 1);
        chk("vec_out_sum", bus.out_sum, v.sum);
        chk("vec_out_id", bus.out_id, v.req);
        chk("vec_err_cnt", err_cnt, st(t_cnt));
        chk("vec_err_acc", err_acc, st(t_acc));
        @(posedge clk); #1;
        chk("vec_idle_valid", bus.out_valid, 0);
        chk("vec_idle_busy", bus.busy, 0);
    endtask

    initial begin
        vecs[0] = '{0, 16'h1234, 16'h0101, 17'h0133F, 1, 10};
        vecs[1] = '{2, 16'h0040, 16'h00C0, 17'h000FF, 1, 1};
        vecs[2] = '{2, 16'h00C0, 16'h0080, 17'h0014F, 1, 15};
        vecs[3] = '{1, 16'hFFFF, 16'h0080, 17'h1007F, 0, 0};
        vecs[4] = '{3, 16'h0000, 16'h0000, 17'h0000F, 1, 15};
        vecs[5] = '{0, 16'hFFFF, 16'hFFFF, 17'h1FFBF, 1, 63};

        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.out_ready = 1'b0;
        pv = '0;
        for (int i = 0; i < NREQ; i++) begin px[i] = '0; py[i] = '0; end
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_sum", bus.out_sum, 0);
        chk("reset_out_id", bus.out_id, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_req_ready", bus.req_ready, 0);
        chk("reset_err_cnt", err_cnt, 0);
        chk("reset_err_acc", err_acc, 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // All requesters valid continuously: strict rotation, one per cycle.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b1; px[i] = 16'($urandom); py[i] = 16'($urandom);
        end
        rec = 1;
        repeat (8) model_cycle(1'b1, 100);
        drain();
        rec = 0;
        chk("t3_count", seen_id.size() >= 8, 1);
        for (int i = 0; i < 8 && i < seen_id.size(); i++) begin
            chk("t3_id_seq", seen_id[i], i % 4);
            chk("t3_back_to_back", seen_cyc[i] - seen_cyc[0], i);
        end
        check_stats("t3");

        // Backpressure: S2 frozen, S1 fills once, then nobody is ready.
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b1; px[i] = 16'($urandom); py[i] = 16'($urandom);
        end
        repeat (5) model_cycle(1'b0, 0);
        chk("t5_all_blocked", bus.req_ready, 0);
        chk("t5_held_valid", bus.out_valid, 1);
        drain();
        check_stats("t5");

        // Random traffic and random consumer stalls.
        repeat (400) model_cycle($urandom_range(3) != 0, 40);
        drain();
        check_stats("rand");

        @(posedge clk); #1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        chk("clr_err_cnt", err_cnt, 0);
        chk("clr_err_acc", err_acc, 0);
        m_cnt = 0;
        m_acc = 0;

        // Reset with both stages full, then requester 0 wins first.
        for (int i = 0; i < NREQ; i++) begin
            pv[i] = 1'b1; px[i] = 16'($urandom); py[i] = 16'($urandom);
        end
        repeat (3) model_cycle(1'b0, 0);
        chk("t6_full_busy", bus.busy, 1);
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            if (!pv[i]) begin
                pv[i] = 1'b1; px[i] = 16'($urandom); py[i] = 16'($urandom);
            end
        end
        model_cycle(1'b1, 0);
        chk("t6_grant0", bus.req_ready, 4'b0001);
        drain();
        check_stats("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

endmodule
